sprite_line_scheduler: RTL
==========================

# sprite_line_scheduler

Per-scanline sprite evaluator that shares the fixed pool of sprite draw slots among all sprites in sprite RAM. On each line-start pulse it scans every sprite entry in priority order, selects the first `SLOT_NUM` sprites that intersect the upcoming scanline, and latches their RAM indices into the slot outputs that feed the per-slot tile draw engines. It sits between the sprite RAM read port and the tile draw slots in the PPU, and runs on the 100 MHz compute clock.

## Interface
Parameters:
- `SPRITE_NUM`, 64: number of sprite RAM entries; must be a power of two.
- `SLOT_NUM`, 6: number of draw slots.
- `POSY_BIT`, 10: width of the Y coordinate.
- `SPRITE_H`, 16: sprite height in lines.

Ports (`IW` = `$clog2(SPRITE_NUM)`):
- `clk`: input, 1 bit. Compute clock.
- `rstn`: input, 1 bit. Asynchronous, active-low reset.
- `lineStart`: input, 1 bit. Single-cycle pulse that requests evaluation for `nextLineY`.
- `frameStart`: input, 1 bit. Single-cycle pulse, once per frame.
- `nextLineY`: input, `POSY_BIT` bits. Scanline to evaluate; sampled on an accepted `lineStart`.
- `ramIndex`: output, `IW` bits. Sprite RAM read address.
- `ramData`: input, 32 bits. Sprite entry, returned 1 cycle after `ramIndex`.
  - bit 31: enable.
  - bits [19:10]: posY.
  - bits [9:0]: posX, unused here.
- `slotIndex`: output, `SLOT_NUM*IW` bits. Slot k occupies bits [k*IW +: IW].
- `slotValid`: output, `SLOT_NUM` bits. Per-slot occupied flag.
- `lineOverflow`: output, 1 bit. More than `SLOT_NUM` sprites hit the last committed line.
- `busy`: output, 1 bit. High while an evaluation is in progress.
- `done`: output, 1 bit. Single-cycle pulse when the committed outputs update.

## Operation
The block is a state machine with four states:
- IDLE → SCAN on `lineStart`.
- SCAN → DRAIN after the last address has been issued.
- DRAIN → COMMIT.
- COMMIT → IDLE.

IDLE
- `busy`=0.
- An accepted `lineStart` latches `nextLineY` into `lineY`, clears the shadow slots, shadow count and shadow overflow, and sets `issueCnt`=0.
- `lineStart` while `busy`=1 is ignored; there is no queueing.

SCAN
- Each cycle `ramIndex` = (`startIdx` + `issueCnt`) mod `SPRITE_NUM`, then `issueCnt` increments.
- The cycle that issues `issueCnt`=`SPRITE_NUM`-1 moves the FSM to DRAIN.
- `ramIndex` holds its last value in every other state.

Evaluation pipeline (runs in SCAN and DRAIN)
- A 1-cycle delayed copy of the issued index, with a valid bit, travels alongside `ramData`.
- An entry is a hit when enable=1 and `lineY` − posY, computed in `POSY_BIT`+1 bits and interpreted as signed, lies in [0, `SPRITE_H`−1].
- Hit with shadow count < `SLOT_NUM`: the delayed index is written to shadow slot[count], its shadow valid bit is set, and count increments.
- Hit with shadow count = `SLOT_NUM`: shadow overflow is set; no slot changes.
- Order of evaluation is the scan order, so slot 0 holds the highest-priority sprite.

COMMIT
- Shadow slots, shadow valid bits and shadow overflow are copied to `slotIndex`, `slotValid` and `lineOverflow`.
- `done`=1 for this cycle.
- Committed outputs are stable at all other times, so the draw engines never see a partial result.

`startIdx` is 0 unless the Configuration feature is compiled in.

Reset, asserted at any time including mid-scan:
- FSM returns to IDLE.
- All outputs are 0: `slotIndex`, `slotValid`, `lineOverflow`, `busy`, `done` and `ramIndex`.
- The rotation offset is 0.

## Timing
- An accepted `lineStart` in cycle T gives:
  - `busy`=1 from T+1.
  - Addresses issued in cycles T+1 through T+`SPRITE_NUM`.
  - DRAIN in T+`SPRITE_NUM`+1.
  - COMMIT with `done` and new outputs in T+`SPRITE_NUM`+2.
  - `busy`=0 from T+`SPRITE_NUM`+3.
- With defaults this is 66 cycles, well inside one VGA line of 3200 clk cycles.
- A new `lineStart` is accepted no earlier than the first cycle with `busy`=0.
- No hit: all `slotValid` bits are 0 and `lineOverflow`=0.
- Exactly `SLOT_NUM` hits: all `slotValid` bits are 1 and `lineOverflow`=0.
- posY near the top of the range (e.g. 1020 with `lineY`=4) is no hit. The extended-width subtraction must not wrap.

## Configuration
`SPRITE_SCHED_ROTATE_EN`:
- Defined:
  - A rotation offset of `IW` bits increments mod `SPRITE_NUM` on every `frameStart`.
  - `startIdx` = offset, sampled when `lineStart` is accepted.
  - Dropped sprites change from frame to frame (flicker instead of permanent loss).
  - A `frameStart` arriving mid-scan affects only the next evaluation.
- Undefined: `startIdx` is fixed at 0 and `frameStart` is ignored.

## Test plan
- Reset: assert `rstn`=0 mid-SCAN → next cycle `busy`=0, `slotValid`=0, `lineOverflow`=0; a new `lineStart` after release completes normally.
- Sprites 3, 10 and 40 enabled with posY=100 and all others disabled; `lineStart` with `nextLineY`=115 → `done` exactly 66 cycles after the pulse; slots 0..2 = 3, 10, 40; `slotValid`=6'b000111; `lineOverflow`=0.
- Same setup with `nextLineY`=116 → `slotValid`=0.
- Sprites 0..7 enabled with posY=50; `nextLineY`=50 → slots hold 0..5, `slotValid`=6'b111111, `lineOverflow`=1.
- Sprite 5 enabled with posY=1020; `nextLineY`=4 → no hit.
- Sprite 5 with enable=0 and posY=4; `nextLineY`=4 → no hit.
- Second `lineStart` at T+10 → ignored; exactly one `done`; outputs unchanged until COMMIT.
- With `SPRITE_SCHED_ROTATE_EN`: two `frameStart` pulses, then sprites 0..7 hitting → slots = 2..7, `lineOverflow`=1.
- Without `SPRITE_SCHED_ROTATE_EN`: same stimulus → slots = 0..5.

Source files
------------

// File: rtl/sprite_line_scheduler_if.sv
// Interface between the sprite line scheduler, the sprite RAM read port and the slot draw engines.
// The slave modport belongs to the scheduler. The master modport belongs to the surrounding PPU logic.
interface sprite_line_scheduler_if #(
  parameter int unsigned SPRITE_NUM = 64,
  parameter int unsigned SLOT_NUM   = 6,
  parameter int unsigned POSY_BIT   = 10
);
  localparam int unsigned IW = $clog2(SPRITE_NUM);

  logic                     lineStart;
  logic                     frameStart;
  logic [POSY_BIT-1:0]      nextLineY;
  logic [IW-1:0]            ramIndex;
  logic [31:0]              ramData;
  logic [SLOT_NUM*IW-1:0]   slotIndex;
  logic [SLOT_NUM-1:0]      slotValid;
  logic                     lineOverflow;
  logic                     busy;
  logic                     done;

  modport master (
    output lineStart, frameStart, nextLineY, ramData,
    input  ramIndex, slotIndex, slotValid, lineOverflow, busy, done
  );

  modport slave (
    input  lineStart, frameStart, nextLineY, ramData,
    output ramIndex, slotIndex, slotValid, lineOverflow, busy, done
  );
endinterface

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite evaluator: scans sprite RAM and latches the first SLOT_NUM hits into the draw slots.
// The optional macro SPRITE_SCHED_ROTATE_EN rotates the scan start on every frame so that dropped sprites flicker.
module sprite_line_scheduler #(
  parameter int unsigned SPRITE_NUM = 64,
  parameter int unsigned SLOT_NUM   = 6,
  parameter int unsigned POSY_BIT   = 10,
  parameter int unsigned SPRITE_H   = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  sprite_line_scheduler_if.slave bus
);
  localparam int unsigned IW = $clog2(SPRITE_NUM);
  localparam int unsigned CW = $clog2(SLOT_NUM + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  logic [1:0]             state, state_nxt;
  logic [IW-1:0]          issue_cnt, start_idx, rot_offset;
  logic [POSY_BIT-1:0]    line_y;
  logic [IW-1:0]          pipe_idx;
  logic                   pipe_vld;
  logic                   accept, last_issue, hit;
  logic [POSY_BIT:0]      diff;
  logic [SLOT_NUM*IW-1:0] sh_idx, sh_idx_nxt;
  logic [SLOT_NUM-1:0]    sh_vld, sh_vld_nxt;
  logic [CW-1:0]          sh_cnt, sh_cnt_nxt;
  logic                   sh_ovf, sh_ovf_nxt;
  logic                   unused_c;

  assign accept     = (state == S_IDLE) && bus.lineStart;
  assign last_issue = (state == S_SCAN) && (issue_cnt == IW'(SPRITE_NUM - 1));
  assign unused_c   = ^{bus.ramData[30:20], bus.ramData[9:0], bus.frameStart};

`ifdef SPRITE_SCHED_ROTATE_EN
  // The rotation offset advances once per frame. The scan start only picks up the new value on the next accepted line.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)               rot_offset <= '0;
    else if (bus.frameStart) rot_offset <= rot_offset + IW'(1);
  end
`else
  assign rot_offset = '0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.lineStart) state_nxt = S_SCAN;
      S_SCAN:   if (last_issue)    state_nxt = S_DRAIN;
      S_DRAIN:  state_nxt = S_COMMIT;
      S_COMMIT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Address issue. The index is delayed by one cycle so that it lines up with the returning ramData.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      issue_cnt    <= '0;
      start_idx    <= '0;
      line_y       <= '0;
      bus.ramIndex <= '0;
      pipe_idx     <= '0;
      pipe_vld     <= 1'b0;
    end else begin
      pipe_vld <= (state == S_SCAN);
      pipe_idx <= bus.ramIndex;
      if (accept) begin
        line_y       <= bus.nextLineY;
        start_idx    <= rot_offset;
        issue_cnt    <= '0;
        bus.ramIndex <= rot_offset;
      end else if (state == S_SCAN) begin
        issue_cnt <= issue_cnt + IW'(1);
        if (!last_issue) bus.ramIndex <= start_idx + issue_cnt + IW'(1);
      end
    end
  end

  // The one extra bit keeps a sprite positioned below the line negative instead of letting the subtraction wrap.
  assign diff = {1'b0, line_y} - {1'b0, POSY_BIT'(bus.ramData[19:10])};
  assign hit  = pipe_vld && bus.ramData[31] && !diff[POSY_BIT] &&
                (diff[POSY_BIT-1:0] < POSY_BIT'(SPRITE_H));

  always_comb begin
    sh_idx_nxt = sh_idx;
    sh_vld_nxt = sh_vld;
    sh_cnt_nxt = sh_cnt;
    sh_ovf_nxt = sh_ovf;
    if (hit) begin
      if (sh_cnt == CW'(SLOT_NUM)) begin
        sh_ovf_nxt = 1'b1;
      end else begin
        for (int k = 0; k < SLOT_NUM; k++) begin
          if (sh_cnt == CW'(k)) begin
            sh_idx_nxt[k*IW +: IW] = pipe_idx;
            sh_vld_nxt[k]          = 1'b1;
          end
        end
        sh_cnt_nxt = sh_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_idx <= '0;
      sh_vld <= '0;
      sh_cnt <= '0;
      sh_ovf <= 1'b0;
    end else if (accept) begin
      sh_idx <= '0;
      sh_vld <= '0;
      sh_cnt <= '0;
      sh_ovf <= 1'b0;
    end else begin
      sh_idx <= sh_idx_nxt;
      sh_vld <= sh_vld_nxt;
      sh_cnt <= sh_cnt_nxt;
      sh_ovf <= sh_ovf_nxt;
    end
  end

  // Committed outputs take the shadow values including the final drained entry, so they first appear in COMMIT.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.slotIndex    <= '0;
      bus.slotValid    <= '0;
      bus.lineOverflow <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
    end else begin
      bus.busy <= (state_nxt != S_IDLE);
      bus.done <= (state_nxt == S_COMMIT);
      if (state == S_DRAIN) begin
        bus.slotIndex    <= sh_idx_nxt;
        bus.slotValid    <= sh_vld_nxt;
        bus.lineOverflow <= sh_ovf_nxt;
      end
    end
  end
endmodule
